data_cache: RTL and testbench

Direct-mapped, write-through, no-write-allocate data cache between the MIPS core's data port and the main data memory. It consumes the core's `mem_addr`, `mem_data_in`, `mem_write_en` and read strobe, and returns `mem_data_out` in the core's 4-byte big-endian array format. It stalls the core on read misses and on every store, and moves traffic to backing memory over a req/ack handshake. It also keeps hit/miss counters for performance runs.

---
 rtl/data_cache.sv | 84 ++++++++
 tb/tb_data_cache.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/data_cache.sv
// data_cache: direct-mapped, write-through, no-write-allocate data cache
// with a req/ack backing-memory port and load hit/miss counters.
module data_cache #(
  parameter int INDEX_BITS = 3
) (
  input  logic        clk,
  input  logic        rst_b,
  input  logic [31:0] mem_addr,
  input  logic [7:0]  mem_data_in [0:3],
  input  logic        mem_read_en,
  input  logic        mem_write_en,
  output logic [7:0]  mem_data_out [0:3],
  output logic        cache_stall,
  output logic        bk_req,
  output logic        bk_we,
  output logic [31:0] bk_addr,
  output logic [31:0] bk_wdata,
  input  logic        bk_ack,
  input  logic [31:0] bk_rdata,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
);
  localparam int LINES = 1 << INDEX_BITS;
  localparam int TAG_BITS = 30 - INDEX_BITS;
  typedef enum logic [1:0] {IDLE, FILL, WTHRU, WDONE} state_t;
  state_t state, state_nx;
  logic [LINES-1:0] valid;
  logic [TAG_BITS-1:0] tags [LINES];
  logic [31:0] lines [LINES];
  logic [INDEX_BITS-1:0] idx;
  logic [TAG_BITS-1:0] tag;
  logic hit, rd, wr;
  assign idx = mem_addr[INDEX_BITS+1:2];
  assign tag = mem_addr[31:INDEX_BITS+2];
  assign hit = valid[idx] && tags[idx] == tag;
  assign wr = mem_write_en;
  assign rd = mem_read_en && !mem_write_en;
  assign bk_addr = mem_addr & ~32'h3;
  assign bk_wdata = {mem_data_in[0], mem_data_in[1], mem_data_in[2], mem_data_in[3]};
  assign bk_req = state == FILL || state == WTHRU;
  assign bk_we = state == WTHRU;
  assign mem_data_out[0] = lines[idx][31:24];
  assign mem_data_out[1] = lines[idx][23:16];
  assign mem_data_out[2] = lines[idx][15:8];
  assign mem_data_out[3] = lines[idx][7:0];
  // WDONE releases the core for one cycle without a lookup, so the held store is not re-issued
  always_comb begin
    state_nx = state;
    cache_stall = 1'b1;
    case (state)
      IDLE: begin
        cache_stall = wr || (rd && !hit);
        state_nx = wr ? WTHRU : (rd && !hit) ? FILL : IDLE;
      end
      FILL: state_nx = bk_ack ? IDLE : FILL;
      WTHRU: state_nx = bk_ack ? WDONE : WTHRU;
      default: begin
        cache_stall = 1'b0;
        state_nx = IDLE;
      end
    endcase
  end
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state <= IDLE;
      valid <= '0;
      hit_count <= '0;
      miss_count <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && rd && hit) hit_count <= hit_count + 32'd1;
      if (state == IDLE && rd && !hit) miss_count <= miss_count + 32'd1;
      if (state == FILL && bk_ack) valid[idx] <= 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (state == FILL && bk_ack) begin
      tags[idx] <= tag;
      lines[idx] <= bk_rdata;
    end else if (state == WTHRU && bk_ack && hit) begin
      lines[idx] <= bk_wdata;
    end
  end
endmodule

// File: tb/tb_data_cache.sv
// tb_data_cache: directed scoreboard bench for data_cache with a latency-programmable backing memory.
module tb_data_cache;
  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } txn_t;
  logic        clk = 1'b0;
  logic        rst_b;
  logic [31:0] mem_addr;
  logic [7:0]  mem_data_in [0:3];
  logic        mem_read_en, mem_write_en;
  logic [7:0]  mem_data_out [0:3];
  logic        cache_stall, bk_req, bk_we, bk_ack;
  logic [31:0] bk_addr, bk_wdata, bk_rdata, hit_count, miss_count;
  logic        resp_ack = 1'b0;
  logic        manual_ack;
  logic        auto_ack;
  int          lat;
  logic [31:0] bmem [0:63];
  txn_t        exp_bk [$];
  logic [31:0] exp_rd [$];
  int          tests = 0;
  int          fails = 0;

  data_cache #(.INDEX_BITS(3)) dut (
    .clk(clk), .rst_b(rst_b), .mem_addr(mem_addr), .mem_data_in(mem_data_in),
    .mem_read_en(mem_read_en), .mem_write_en(mem_write_en), .mem_data_out(mem_data_out),
    .cache_stall(cache_stall), .bk_req(bk_req), .bk_we(bk_we), .bk_addr(bk_addr),
    .bk_wdata(bk_wdata), .bk_ack(bk_ack), .bk_rdata(bk_rdata),
    .hit_count(hit_count), .miss_count(miss_count)
  );

  always #5 clk = ~clk;
  assign bk_ack = resp_ack | manual_ack;
  assign bk_rdata = bmem[bk_addr[7:2]];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_cnt(input logic [31:0] h, input logic [31:0] m);
    check("hit_count", hit_count, h);
    check("miss_count", miss_count, m);
  endtask

  // Backing memory: acks in the lat-th cycle of bk_req high and checks each transaction on its first cycle
  initial begin
    int cnt = 0;
    txn_t e;
    for (int i = 0; i < 64; i++) bmem[i] = 32'h0;
    bmem[4]  = 32'hDEADBEEF;
    bmem[20] = 32'h55667788;
    bmem[11] = 32'hCAFEF00D;
    bmem[28] = 32'h77777777;
    forever begin
      @(negedge clk);
      resp_ack = 1'b0;
      if (bk_req) begin
        if (cnt == 0) begin
          e = exp_bk.size() != 0 ? exp_bk.pop_front() : txn_t'{1'b1, 32'hFFFF_FFFF, 32'h0};
          check("bk_we", bk_we, e.we);
          check("bk_addr", bk_addr, e.addr);
          if (e.we) check("bk_wdata", bk_wdata, e.wdata);
        end
        cnt++;
        if (auto_ack && cnt == lat) begin
          resp_ack = 1'b1;
          if (bk_we) bmem[bk_addr[7:2]] = bk_wdata;
        end
      end else begin
        cnt = 0;
      end
    end
  end

  task automatic do_read(input logic [31:0] a, input logic [31:0] d, input int stalls);
    int n = 0;
    mem_addr = a;
    mem_read_en = 1'b1;
    if (stalls > 0) exp_bk.push_back(txn_t'{1'b0, a, 32'h0});
    exp_rd.push_back(d);
    @(negedge clk);
    while (cache_stall && n < 50) begin
      n++;
      @(negedge clk);
    end
    check("rd_stall", n, stalls);
    check("rd_data", {mem_data_out[0], mem_data_out[1], mem_data_out[2], mem_data_out[3]},
          exp_rd.pop_front());
    @(posedge clk);
    #1 mem_read_en = 1'b0;
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input int stalls);
    int n = 0;
    mem_addr = a;
    mem_write_en = 1'b1;
    for (int i = 0; i < 4; i++) mem_data_in[i] = d[31-8*i -: 8];
    exp_bk.push_back(txn_t'{1'b1, a, d});
    @(negedge clk);
    while (cache_stall && n < 50) begin
      n++;
      @(negedge clk);
    end
    check("wr_stall", n, stalls);
    check("wdone_req", bk_req, 1'b0);
    @(posedge clk);
    #1 mem_write_en = 1'b0;
    @(negedge clk);
    check("post_wdone_stall", cache_stall, 1'b0);
    check("post_wdone_req", bk_req, 1'b0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_b = 1'b0;
    mem_addr = 32'h0;
    for (int i = 0; i < 4; i++) mem_data_in[i] = 8'h0;
    mem_read_en = 1'b0;
    mem_write_en = 1'b0;
    manual_ack = 1'b0;
    auto_ack = 1'b1;
    lat = 3;
    repeat (2) @(posedge clk);
    #1;
    check("rst_stall", cache_stall, 1'b0);
    check("rst_bk_req", bk_req, 1'b0);
    check("rst_bk_we", bk_we, 1'b0);
    chk_cnt(0, 0);
    rst_b = 1'b1;
    @(posedge clk);
    #1;
    do_read(32'h10, 32'hDEADBEEF, 4);
    chk_cnt(1, 1);
    do_read(32'h10, 32'hDEADBEEF, 0);
    chk_cnt(2, 1);
    do_write(32'h10, 32'h11223344, 4);
    do_read(32'h10, 32'h11223344, 0);
    chk_cnt(3, 1);
    do_write(32'h30, 32'hAABBCCDD, 4);
    do_read(32'h30, 32'hAABBCCDD, 4);
    do_read(32'h10, 32'h11223344, 4);
    do_read(32'h50, 32'h55667788, 4);
    do_read(32'h10, 32'h11223344, 4);
    chk_cnt(7, 5);
    lat = 1;
    do_read(32'h2C, 32'hCAFEF00D, 2);
    do_write(32'h2C, 32'h01020304, 2);
    do_read(32'h2C, 32'h01020304, 0);
    chk_cnt(9, 6);
    auto_ack = 1'b0;
    mem_addr = 32'h70;
    mem_read_en = 1'b1;
    exp_bk.push_back(txn_t'{1'b0, 32'h70, 32'h0});
    @(posedge clk);
    #1;
    @(posedge clk);
    #1 rst_b = 1'b0;
    #1;
    check("midfill_rst_req", bk_req, 1'b0);
    chk_cnt(0, 0);
    mem_read_en = 1'b0;
    @(posedge clk);
    #1 rst_b = 1'b1;
    manual_ack = 1'b1;
    @(posedge clk);
    #1 manual_ack = 1'b0;
    check("late_ack_req", bk_req, 1'b0);
    check("late_ack_stall", cache_stall, 1'b0);
    chk_cnt(0, 0);
    auto_ack = 1'b1;
    lat = 2;
    do_read(32'h70, 32'h77777777, 3);
    do_read(32'h2C, 32'h01020304, 3);
    chk_cnt(2, 2);
    check("bk_queue_empty", exp_bk.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
